// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared constants and types for the pipelined core front end:
//               default reset/exception addresses, exception cause codes and
//               the next-PC redirect-select enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  // Default fetch addresses (32-bit; consumers truncate to their PC width)
  localparam logic [31:0] c_reset_pc_def   = 32'h0000_0000;
  localparam logic [31:0] c_exc_vector_def = 32'h0000_0080;

  // Exception cause codes (4-bit, MIPS-style numbering)
  localparam int          c_cause_w_def  = 4;
  localparam logic [3:0]  c_cause_int    = 4'd0;
  localparam logic [3:0]  c_cause_addr   = 4'd4;   // misaligned fetch target
  localparam logic [3:0]  c_cause_sys    = 4'd8;
  localparam logic [3:0]  c_cause_bp     = 4'd9;
  localparam logic [3:0]  c_cause_ri     = 4'd10;
  localparam logic [3:0]  c_cause_ov     = 4'd12;

  // Next-PC source, listed from highest to lowest priority
  typedef enum logic [2:0] {
    EXC     = 3'd0,
    ADDRERR = 3'd1,
    HOLD    = 3'd2,
    ERET    = 3'd3,
    JR      = 3'd4,
    JUMP    = 3'd5,
    BRANCH  = 3'd6,
    SEQ     = 3'd7
  } redirect_sel_e;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/pc_target_calc.sv
`default_nettype none
// ============================================================================
// Module      : pc_target_calc
// Description : Purely combinational target arithmetic for the PC unit.
//               All sums are modulo 2^ADDR_W.
// Ports       : pc        in  current fetch address
//               id_pc     in  PC of the instruction in ID
//               id_instr  in  instruction in ID ([15:0] offset, [25:0] index)
//               pc_plus4  out pc + 4
//               br_tgt    out id_pc + 4 + sext(offset) << 2
//               j_tgt     out {(id_pc+4)[ADDR_W-1:28], index, 2'b00}
//               link_addr out id_pc + 8
// Revision    : 1.0 - initial release
// ============================================================================
module pc_target_calc #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] br_tgt,
  output logic [ADDR_W-1:0] j_tgt,
  output logic [ADDR_W-1:0] link_addr
);

  logic [ADDR_W-1:0] w_id_pc_plus4;
  logic [ADDR_W-1:0] w_br_off;
  logic [5:0]        w_unused_opcode;

  // Opcode field is decoded elsewhere; only the immediates matter here.
  assign w_unused_opcode = id_instr[31:26];

  assign pc_plus4      = pc + ADDR_W'(4);
  assign w_id_pc_plus4 = id_pc + ADDR_W'(4);
  assign link_addr     = id_pc + ADDR_W'(8);

  // Sign-extended word offset already shifted into byte units.
  assign w_br_off = {{(ADDR_W-18){id_instr[15]}}, id_instr[15:0], 2'b00};
  assign br_tgt   = w_id_pc_plus4 + w_br_off;

  // Jump keeps the region bits above bit 27 of the sequential PC; at a
  // 28-bit PC there is no region and the target is the index alone.
  generate
    if (ADDR_W > 28) begin : g_jump_region
      assign j_tgt = {w_id_pc_plus4[ADDR_W-1:28], id_instr[25:0], 2'b00};
    end else begin : g_jump_flat
      assign j_tgt = {id_instr[25:0], 2'b00};
    end
  endgenerate

endmodule : pc_target_calc
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Architectural PC register for IF of the pipelined core.
//               Resolves ID redirects (beq/bne, j/jal, jr, eret), enters the
//               exception vector on a later-stage exception or a misaligned
//               jr target, keeps the EPC/cause pair and drives the IF/ID and
//               ID/EX flush controls.
// Ports       : clk, rst_n                  clock, async active-low reset
//               stall                       hold PC, ignore ID redirects
//               id_valid, id_instr, id_pc   instruction presented in ID
//               is_branch, is_bne, cmp_eq   conditional branch decode/compare
//               is_jump, is_jr, jr_target   unconditional redirects
//               exc_req, exc_pc, exc_cause  exception pulse from later stage
//               eret                        return from exception (in ID)
//               pc, pc_plus4, link_addr     fetch address and derived values
//               flush_if, flush_id          squash controls (combinational)
//               epc, cause                  saved exception state
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
  import pipeline_pkg::*;
#(
  parameter int                 ADDR_W     = 32,
  parameter logic [31:0]        RESET_PC   = c_reset_pc_def,
  parameter logic [31:0]        EXC_VECTOR = c_exc_vector_def,
  parameter int                 CAUSE_W    = c_cause_w_def,
  parameter logic [CAUSE_W-1:0] CAUSE_ADDR = CAUSE_W'(c_cause_addr)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                id_valid,
  input  logic [31:0]         id_instr,
  input  logic [ADDR_W-1:0]   id_pc,
  input  logic                is_branch,
  input  logic                is_bne,
  input  logic                cmp_eq,
  input  logic                is_jump,
  input  logic                is_jr,
  input  logic [ADDR_W-1:0]   jr_target,
  input  logic                exc_req,
  input  logic [ADDR_W-1:0]   exc_pc,
  input  logic [CAUSE_W-1:0]  exc_cause,
  input  logic                eret,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W-1:0]   pc_plus4,
  output logic [ADDR_W-1:0]   link_addr,
  output logic                flush_if,
  output logic                flush_id,
  output logic [ADDR_W-1:0]   epc,
  output logic [CAUSE_W-1:0]  cause
);

  localparam logic [ADDR_W-1:0] c_reset_pc   = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] c_exc_vector = EXC_VECTOR[ADDR_W-1:0];

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_epc;
  logic [CAUSE_W-1:0] r_cause;

  logic [ADDR_W-1:0]  w_br_tgt;
  logic [ADDR_W-1:0]  w_j_tgt;
  logic [ADDR_W-1:0]  w_pc_plus4;
  logic [ADDR_W-1:0]  w_pc_next;
  logic               w_id_live;
  logic               w_taken;
  logic               w_jr_misalign;
  logic               w_flush_if;
  logic               w_flush_id;
  redirect_sel_e      w_sel;

  pc_target_calc #(
    .ADDR_W (ADDR_W)
  ) u_target_calc (
    .pc        (r_pc),
    .id_pc     (id_pc),
    .id_instr  (id_instr),
    .pc_plus4  (w_pc_plus4),
    .br_tgt    (w_br_tgt),
    .j_tgt     (w_j_tgt),
    .link_addr (link_addr)
  );

  // An ID instruction can only redirect when it is real and not stalled.
  assign w_id_live     = id_valid & ~stall;
  assign w_taken       = w_id_live & is_branch & (cmp_eq ^ is_bne);
  assign w_jr_misalign = w_id_live & is_jr & (jr_target[1:0] != 2'b00);

  // Redirect priority. Stall sits below the two exception sources so a
  // fault is never lost behind a hazard; jump sits above branch so a bad
  // decode asserting both still follows the jump.
  always_comb begin
    w_sel = SEQ;
    if (exc_req)                    w_sel = EXC;
    else if (w_jr_misalign)         w_sel = ADDRERR;
    else if (stall)                 w_sel = HOLD;
    else if (id_valid && eret)      w_sel = ERET;
    else if (id_valid && is_jr)     w_sel = JR;
    else if (id_valid && is_jump)   w_sel = JUMP;
    else if (w_taken)               w_sel = BRANCH;
  end

  always_comb begin
    w_pc_next  = w_pc_plus4;
    w_flush_if = 1'b0;
    w_flush_id = 1'b0;
    case (w_sel)
      EXC, ADDRERR: begin
        w_pc_next  = c_exc_vector;
        w_flush_if = 1'b1;
        w_flush_id = 1'b1;
      end
      HOLD: begin
        w_pc_next = r_pc;
      end
      ERET: begin
        w_pc_next  = r_epc;
        w_flush_if = 1'b1;
      end
      JR: begin
        w_pc_next  = jr_target;
        w_flush_if = 1'b1;
      end
      JUMP: begin
        w_pc_next  = w_j_tgt;
        w_flush_if = 1'b1;
      end
      BRANCH: begin
        w_pc_next  = w_br_tgt;
        w_flush_if = 1'b1;
      end
      default: begin
        w_pc_next = w_pc_plus4;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= c_reset_pc;
      r_epc   <= '0;
      r_cause <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_sel == EXC) begin
        r_epc   <= exc_pc;
        r_cause <= exc_cause;
      end else if (w_sel == ADDRERR) begin
        r_epc   <= id_pc;
        r_cause <= CAUSE_ADDR;
      end
    end
  end

  // Flushes are masked during reset so in-flight redirects are dropped.
  assign flush_if = rst_n & w_flush_if;
  assign flush_id = rst_n & w_flush_id;
  assign pc       = r_pc;
  assign pc_plus4 = w_pc_plus4;
  assign epc      = r_epc;
  assign cause    = r_cause;

endmodule : pc_unit
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Self-checking bench for pc_unit. A behavioural model tracks
//               the architectural PC/EPC/cause; every falling edge compares
//               all DUT outputs against it. Directed vectors add literal
//               expectations at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall, id_valid, is_branch, is_bne, cmp_eq, is_jump, is_jr;
  logic        exc_req, eret;
  logic [31:0] id_instr, id_pc, jr_target, exc_pc;
  logic [3:0]  exc_cause;
  logic [31:0] pc, pc_plus4, link_addr, epc;
  logic [3:0]  cause;
  logic        flush_if, flush_id;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state
  logic [31:0] m_pc, m_epc;
  logic [3:0]  m_cause;

  pc_unit #(
    .ADDR_W     (32),
    .RESET_PC   (32'h0000_0000),
    .EXC_VECTOR (32'h0000_0080),
    .CAUSE_W    (4),
    .CAUSE_ADDR (4'd4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .id_valid  (id_valid),
    .id_instr  (id_instr),
    .id_pc     (id_pc),
    .is_branch (is_branch),
    .is_bne    (is_bne),
    .cmp_eq    (cmp_eq),
    .is_jump   (is_jump),
    .is_jr     (is_jr),
    .jr_target (jr_target),
    .exc_req   (exc_req),
    .exc_pc    (exc_pc),
    .exc_cause (exc_cause),
    .eret      (eret),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .link_addr (link_addr),
    .flush_if  (flush_if),
    .flush_id  (flush_id),
    .epc       (epc),
    .cause     (cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_misaligned_jr();
    return id_valid && !stall && is_jr && (jr_target % 4 != 0);
  endfunction

  function automatic bit m_taken();
    return id_valid && !stall && is_branch && (cmp_eq != is_bne);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc    <= 32'h0;
      m_epc   <= 32'h0;
      m_cause <= 4'h0;
    end else if (exc_req) begin
      m_pc    <= 32'h80;
      m_epc   <= exc_pc;
      m_cause <= exc_cause;
    end else if (m_misaligned_jr()) begin
      m_pc    <= 32'h80;
      m_epc   <= id_pc;
      m_cause <= 4'd4;
    end else if (stall) begin
      m_pc <= m_pc;
    end else if (id_valid && eret) begin
      m_pc <= m_epc;
    end else if (id_valid && is_jr) begin
      m_pc <= jr_target;
    end else if (id_valid && is_jump) begin
      // region of (id_pc+4) above bit 27, index scaled to bytes
      m_pc <= ((id_pc + 32'd4) / 32'h1000_0000) * 32'h1000_0000
              + {6'd0, id_instr[25:0]} * 32'd4;
    end else if (m_taken()) begin
      m_pc <= id_pc + 32'd4 + 32'($signed(id_instr[15:0]) * 4);
    end else begin
      m_pc <= m_pc + 32'd4;
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_fi, exp_fd;
      exp_fi = 1'b0;
      exp_fd = 1'b0;
      if (rst_n) begin
        if (exc_req || m_misaligned_jr()) begin
          exp_fi = 1'b1;
          exp_fd = 1'b1;
        end else if (!stall && id_valid && (eret || is_jr || is_jump))
          exp_fi = 1'b1;
        else if (m_taken())
          exp_fi = 1'b1;
      end
      check("pc",        pc,        m_pc);
      check("pc_plus4",  pc_plus4,  m_pc + 32'd4);
      check("link_addr", link_addr, id_pc + 32'd8);
      check("flush_if",  {31'd0, flush_if}, {31'd0, exp_fi});
      check("flush_id",  {31'd0, flush_id}, {31'd0, exp_fd});
      check("epc",       epc,       m_epc);
      check("cause",     {28'd0, cause}, {28'd0, m_cause});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    stall = 0; id_valid = 0; is_branch = 0; is_bne = 0; cmp_eq = 0;
    is_jump = 0; is_jr = 0; exc_req = 0; eret = 0;
    id_instr = 32'h0; id_pc = 32'h0; jr_target = 32'h0;
    exc_pc = 32'h0; exc_cause = 4'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b1;
    check("rst_pc", pc, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);
    check("rst_epc", epc, 32'h0);
    check("rst_cause", {28'd0, cause}, 32'h0);
    repeat (7) cyc();
    check("run_pc_1c", pc, 32'h1C);

    // In-flight jump when reset hits mid-cycle
    id_valid = 1; is_jump = 1; id_instr = 32'h0C00_0100; id_pc = 32'h20;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_flush", {31'd0, flush_if}, 32'h0);
    cyc();
    clr();
    rst_n = 1'b1;
    check("rel_pc0", pc, 32'h0);
    cyc(); check("rel_pc4", pc, 32'h4);
    cyc(); check("rel_pc8", pc, 32'h8);

    // beq taken: 0x10 + 4 - 8 = 0x0C
    id_valid = 1; is_branch = 1; cmp_eq = 1; id_pc = 32'h10; id_instr = 32'h0000_FFFE;
    #1 check("beq_flush", {31'd0, flush_if}, 32'h1);
    cyc(); check("beq_pc", pc, 32'h0C);
    // bne with equal operands: not taken
    is_bne = 1;
    #1 check("bne_flush", {31'd0, flush_if}, 32'h0);
    cyc(); check("bne_pc", pc, 32'h10);
    clr();

    // jal
    id_valid = 1; is_jump = 1; id_pc = 32'h0040_0020; id_instr = 32'h0C00_0010;
    #1 check("jal_link", link_addr, 32'h0040_0028);
    check("jal_flush", {31'd0, flush_if}, 32'h1);
    cyc(); check("jal_pc", pc, 32'h40);
    clr();

    // Stalled taken branch: 0x40 + 4 + 16 = 0x54
    id_valid = 1; is_branch = 1; cmp_eq = 1; id_pc = 32'h40; id_instr = 32'h0000_0004;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_flush", {31'd0, flush_if}, 32'h0);
      cyc(); check("stall_pc", pc, 32'h40);
    end
    stall = 0;
    #1 check("unstall_flush", {31'd0, flush_if}, 32'h1);
    cyc(); check("unstall_pc", pc, 32'h54);
    clr();

    // Exception overriding a stall
    stall = 1; exc_req = 1; exc_pc = 32'h24; exc_cause = 4'hC;
    #1 check("exc_flush_if", {31'd0, flush_if}, 32'h1);
    check("exc_flush_id", {31'd0, flush_id}, 32'h1);
    cyc();
    check("exc_pc", pc, 32'h80);
    check("exc_epc", epc, 32'h24);
    check("exc_cause", {28'd0, cause}, 32'hC);
    clr();
    cyc(); check("handler_seq", pc, 32'h84);
    id_valid = 1; eret = 1;
    #1 check("eret_flush_id", {31'd0, flush_id}, 32'h0);
    cyc(); check("eret_pc", pc, 32'h24);
    clr();

    // Exception and eret together: exception wins
    exc_req = 1; exc_pc = 32'h30; exc_cause = 4'h9; id_valid = 1; eret = 1;
    cyc();
    check("exc_eret_pc", pc, 32'h80);
    check("exc_eret_epc", epc, 32'h30);
    clr();

    // Jump and taken branch together: jump wins (j_tgt 0x80, br_tgt 0x184)
    id_valid = 1; is_jump = 1; is_branch = 1; cmp_eq = 1;
    id_pc = 32'h100; id_instr = 32'h0000_0020;
    cyc(); check("jump_over_br", pc, 32'h80);
    clr();

    // Redirect fields with id_valid low are ignored
    is_jump = 1; is_jr = 1; eret = 1; jr_target = 32'h102; id_instr = 32'h0000_0400;
    #1 check("invalid_flush", {31'd0, flush_if}, 32'h0);
    cyc(); check("invalid_pc", pc, 32'h84);
    clr();

    // Misaligned jr
    id_valid = 1; is_jr = 1; jr_target = 32'h102; id_pc = 32'h200;
    #1 check("adderr_flush_id", {31'd0, flush_id}, 32'h1);
    cyc();
    check("adderr_pc", pc, 32'h80);
    check("adderr_cause", {28'd0, cause}, 32'h4);
    check("adderr_epc", epc, 32'h200);
    // Same under stall: no exception, epc untouched
    stall = 1; id_pc = 32'h300;
    cyc();
    check("adderr_stall_pc", pc, 32'h80);
    check("adderr_stall_epc", epc, 32'h200);
    clr();

    // Aligned jr to the top of the address space, then wrap
    id_valid = 1; is_jr = 1; jr_target = 32'hFFFF_FFFC;
    cyc();
    check("jr_top_pc", pc, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0);
    clr();
    cyc(); check("wrap_pc", pc, 32'h0);
    cyc();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pc_unit
`default_nettype wire
